// File: rtl/mmcm_drp_sequencer_if.sv
// mmcm_drp_sequencer_if: trigger, table ROM, DRP and MMCM control/status bundle.
// The master side is the sequencer; the slave side is the board/ROM/MMCM environment.
interface mmcm_drp_sequencer_if #(
    parameter int MAX_ENTRIES = 16
);
    localparam int IW = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;

    logic          start_i;
    logic [IW:0]   count_i;
    logic [IW-1:0] idx_o;
    logic [38:0]   entry_i;
    logic [6:0]    daddr_o;
    logic          den_o;
    logic          dwe_o;
    logic [15:0]   di_o;
    logic [15:0]   do_i;
    logic          drdy_i;
    logic          mmcm_rst_o;
    logic          locked_i;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [1:0]    err_code_o;

    modport master (
        input  start_i, count_i, entry_i, do_i, drdy_i, locked_i,
        output idx_o, daddr_o, den_o, dwe_o, di_o, mmcm_rst_o, busy_o, done_o, error_o, err_code_o
    );

    modport slave (
        output start_i, count_i, entry_i, do_i, drdy_i, locked_i,
        input  idx_o, daddr_o, den_o, dwe_o, di_o, mmcm_rst_o, busy_o, done_o, error_o, err_code_o
    );
endinterface

// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer: holds an MMCME2 in reset, read-modify-writes a DRP table, then waits for lock.
// Table entries come from a registered ROM indexed by idx_o; done/error stay sticky until the next start.
module mmcm_drp_sequencer #(
    parameter int MAX_ENTRIES  = 16,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int RST_HOLD     = 4
) (
    input logic                  CLK,
    input logic                  RST,
    mmcm_drp_sequencer_if.master bus
);
    localparam int IW   = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;
    localparam int TMAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [3:0] {IDLE, FETCH, RD, RD_WAIT, WR, WR_WAIT, HOLD, LOCK_WAIT, FAIL} state_t;

    state_t        state_q, state_d;
    logic [IW:0]   count_q, count_d, cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0] idx_q, idx_d;
    logic [6:0]    addr_q, addr_d;
    logic [15:0]   mask_q, mask_d, data_q, data_d, new_q, new_d;
    logic [TW-1:0] tmr_q, tmr_d, tmr_inc;
    logic          rst_q, rst_d, done_q, done_d, err_q, err_d;
    logic [1:0]    code_q, code_d, lock_q;

    assign tmr_inc = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        data_d  = data_q;
        new_d   = new_q;
        tmr_d   = tmr_inc;
        rst_d   = rst_q;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (bus.start_i) begin
                    state_d = FETCH;
                    count_d = bus.count_i;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                end
            end
            // first FETCH cycle only lets the registered ROM catch up with idx
            FETCH: begin
                if (count_q == '0) begin
                    state_d = HOLD;
                    tmr_d   = '0;
                end else if (tmr_q != '0) begin
                    {addr_d, mask_d, data_d} = bus.entry_i;
                    state_d = RD;
                    tmr_d   = '0;
                end
            end
            RD: state_d = RD_WAIT;
            RD_WAIT: begin
                if (bus.drdy_i) begin
                    new_d   = (bus.do_i & mask_q) | (data_q & ~mask_q);
                    state_d = WR;
                    tmr_d   = '0;
                end else if (tmr_inc >= TW'(DRDY_TIMEOUT)) begin
                    state_d = FAIL;
                    code_d  = 2'd1;
                end
            end
            WR: state_d = WR_WAIT;
            WR_WAIT: begin
                if (bus.drdy_i) begin
                    cnt_d   = cnt_inc;
                    tmr_d   = '0;
                    state_d = (cnt_inc == count_q) ? HOLD : FETCH;
                    idx_d   = (cnt_inc == count_q) ? idx_q : cnt_inc[IW-1:0];
                end else if (tmr_inc >= TW'(DRDY_TIMEOUT)) begin
                    state_d = FAIL;
                    code_d  = 2'd2;
                end
            end
            HOLD: begin
                if (tmr_inc >= TW'(RST_HOLD)) begin
                    rst_d   = 1'b0;
                    state_d = LOCK_WAIT;
                    tmr_d   = '0;
                end
            end
            // a lock still asserted from before the reset must not count
            LOCK_WAIT: begin
                if (tmr_q >= TW'(4) && lock_q[1]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (tmr_inc >= TW'(LOCK_TIMEOUT)) begin
                    state_d = FAIL;
                    code_d  = 2'd3;
                end
            end
            FAIL: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == FAIL) begin
            err_d = 1'b1;
            rst_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            count_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            new_q   <= '0;
            tmr_q   <= '0;
            rst_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'd0;
            lock_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            new_q   <= new_d;
            tmr_q   <= tmr_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            lock_q  <= {lock_q[0], bus.locked_i};
        end
    end

    assign bus.idx_o      = idx_q;
    assign bus.daddr_o    = addr_q;
    assign bus.den_o      = (state_q == RD) || (state_q == WR);
    assign bus.dwe_o      = state_q == WR;
    assign bus.di_o       = new_q;
    assign bus.mmcm_rst_o = rst_q;
    assign bus.busy_o     = state_q != IDLE;
    assign bus.done_o     = done_q;
    assign bus.error_o    = err_q;
    assign bus.err_code_o = code_q;
endmodule

// File: tb/tb_mmcm_drp_sequencer.sv
// tb_mmcm_drp_sequencer: directed checks of DRP read-modify-write, timeouts, lock wait and reset abort.
// A registered ROM and a DRP responder with programmable latency stand in for the board.
module tb_mmcm_drp_sequencer;
    localparam int TO = 64;
    localparam int LT = 256;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mmcm_drp_sequencer_if #(.MAX_ENTRIES(16)) bus ();

    mmcm_drp_sequencer #(
        .MAX_ENTRIES(16), .DRDY_TIMEOUT(TO), .LOCK_TIMEOUT(LT), .RST_HOLD(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    logic [38:0] rom [16];
    always @(posedge CLK) bus.entry_i <= rom[bus.idx_o];

    int          lat = 3, drop_rd = -1, rd_n = 0, wr_n = 0, pend = 0, viol = 0;
    int          rd0, wr0;
    logic [15:0] rd_data = 16'hA123;
    logic        mdl_drdy = 1'b0, inj_drdy = 1'b0, prev_den = 1'b0;
    logic [6:0]  exp_addr [3] = '{7'h08, 7'h09, 7'h14};
    logic [15:0] exp_di   [3] = '{16'hA145, 16'h1223, 16'hBEEF};

    assign bus.drdy_i = mdl_drdy | inj_drdy;

    // DRP responder: answers each DEN after lat cycles, optionally swallowing one read
    always @(negedge CLK) begin
        mdl_drdy = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                mdl_drdy = 1'b1;
                bus.do_i = rd_data;
            end
        end
        if (bus.den_o) begin
            if (prev_den || pend > 0) viol++;
            if (bus.dwe_o) wr_n++;
            else rd_n++;
            if (bus.dwe_o || rd_n != drop_rd) pend = lat;
        end
        if (bus.done_o && bus.error_o) viol++;
        prev_den = bus.den_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic start(input int cnt);
        bus.count_i = 5'(cnt);
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_den(input string tag);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (!bus.den_o && n < 40);
        chk(tag, 32'(bus.den_o), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (bus.busy_o && n < 60);
        chk(tag, 32'(bus.busy_o), 0);
    endtask

    task automatic wait_rst_low(input string tag);
        int n = 0;
        do begin
            tick(1);
            n++;
        end while (bus.mmcm_rst_o && n < 40);
        chk(tag, 32'(bus.mmcm_rst_o), 0);
    endtask

    initial begin
        bus.start_i  = 1'b0;
        bus.count_i  = '0;
        bus.locked_i = 1'b0;
        bus.do_i     = '0;
        rom[0] = {7'h08, 16'hF000, 16'h0145};
        rom[1] = {7'h09, 16'h00FF, 16'h1200};
        rom[2] = {7'h14, 16'h0000, 16'hBEEF};
        for (int i = 3; i < 16; i++) rom[i] = '0;
        tick(3);
        RST = 1'b0;
        tick(1);
        chk("reset_ctrl", 32'({bus.den_o, bus.dwe_o, bus.mmcm_rst_o, bus.busy_o, bus.done_o, bus.error_o, bus.err_code_o}), 0);
        chk("reset_bus", 32'({bus.idx_o, bus.daddr_o, bus.di_o}), 0);

        // single entry: exact cycle timeline
        start(1);
        chk("t1_start", 32'({bus.busy_o, bus.mmcm_rst_o, bus.idx_o}), 32'({1'b1, 1'b1, 4'h0}));
        tick(2);
        chk("t1_rd", 32'({bus.den_o, bus.dwe_o, bus.daddr_o}), 32'({1'b1, 1'b0, 7'h08}));
        tick(1);
        chk("t1_den_gap", 32'(bus.den_o), 0);
        tick(3);
        chk("t1_wr", 32'({bus.den_o, bus.dwe_o, bus.daddr_o, bus.di_o}), 32'({1'b1, 1'b1, 7'h08, 16'hA145}));
        chk("t1_rst_wr", 32'(bus.mmcm_rst_o), 1);
        tick(7);
        chk("t1_rst_hold", 32'(bus.mmcm_rst_o), 1);
        tick(1);
        chk("t1_rst_rel", 32'({bus.mmcm_rst_o, bus.busy_o}), 32'({1'b0, 1'b1}));
        tick(10);
        bus.locked_i = 1'b1;
        tick(2);
        chk("t1_not_done", 32'(bus.done_o), 0);
        tick(1);
        chk("t1_done", 32'({bus.done_o, bus.busy_o, bus.error_o, bus.err_code_o}), 32'({1'b1, 1'b0, 1'b0, 2'd0}));
        chk("t1_rd_n", rd_n, 1);
        chk("t1_wr_n", wr_n, 1);
        bus.locked_i = 1'b0;

        // three entries in index order
        rd0 = rd_n;
        wr0 = wr_n;
        start(3);
        for (int k = 0; k < 3; k++) begin
            wait_den("t2_rd_den");
            chk("t2_rd", 32'({bus.dwe_o, bus.daddr_o, bus.idx_o}), 32'({1'b0, exp_addr[k], 4'(k)}));
            wait_den("t2_wr_den");
            chk("t2_wr", 32'({bus.dwe_o, bus.daddr_o, bus.di_o}), 32'({1'b1, exp_addr[k], exp_di[k]}));
        end
        bus.locked_i = 1'b1;
        wait_idle("t2_idle");
        chk("t2_done", 32'({bus.done_o, bus.error_o}), 32'({1'b1, 1'b0}));
        chk("t2_rd_n", rd_n - rd0, 3);
        chk("t2_wr_n", wr_n - wr0, 3);
        bus.locked_i = 1'b0;

        // second read never answered
        drop_rd = rd_n + 2;
        start(2);
        wait_den("t3_rd1");
        wait_den("t3_wr1");
        wait_den("t3_rd2");
        chk("t3_rd2_addr", 32'({bus.dwe_o, bus.daddr_o}), 32'({1'b0, 7'h09}));
        tick(TO - 1);
        chk("t3_pre", 32'(bus.error_o), 0);
        tick(1);
        chk("t3_err", 32'({bus.error_o, bus.err_code_o, bus.mmcm_rst_o, bus.done_o}), 32'({1'b1, 2'd1, 1'b0, 1'b0}));
        tick(1);
        chk("t3_idle", 32'({bus.busy_o, bus.error_o}), 32'({1'b0, 1'b1}));
        drop_rd = -1;

        // lock never arrives, then a clean rerun
        start(1);
        wait_rst_low("t4_rel");
        tick(LT - 1);
        chk("t4_pre", 32'(bus.error_o), 0);
        tick(1);
        chk("t4_err", 32'({bus.error_o, bus.err_code_o, bus.done_o}), 32'({1'b1, 2'd3, 1'b0}));
        tick(1);
        start(1);
        chk("t4_clear", 32'({bus.error_o, bus.err_code_o, bus.busy_o}), 32'({1'b0, 2'd0, 1'b1}));
        bus.locked_i = 1'b1;
        wait_idle("t4_idle");
        chk("t4_done", 32'({bus.done_o, bus.error_o}), 32'({1'b1, 1'b0}));
        bus.locked_i = 1'b0;

        // reset while waiting for the write DRDY
        lat = 10;
        start(1);
        wait_den("t5_rd");
        wait_den("t5_wr");
        tick(2);
        chk("t5_wr_wait", 32'({bus.busy_o, bus.mmcm_rst_o}), 32'({1'b1, 1'b1}));
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        chk("t5_abort_ctrl", 32'({bus.den_o, bus.dwe_o, bus.mmcm_rst_o, bus.busy_o, bus.done_o, bus.error_o, bus.err_code_o}), 0);
        chk("t5_abort_bus", 32'({bus.idx_o, bus.daddr_o, bus.di_o}), 0);
        tick(15);
        lat = 3;
        chk("t5_stray_drdy", 32'({bus.busy_o, bus.den_o}), 0);
        rd0 = rd_n;
        wr0 = wr_n;
        start(0);
        tick(4);
        chk("t5_hold", 32'(bus.mmcm_rst_o), 1);
        tick(1);
        chk("t5_rel", 32'(bus.mmcm_rst_o), 0);
        bus.locked_i = 1'b1;
        wait_idle("t5_idle");
        chk("t5_done", 32'(bus.done_o), 1);
        chk("t5_no_den", (rd_n - rd0) + (wr_n - wr0), 0);
        bus.locked_i = 1'b0;

        // DRDY while idle and START while busy are both ignored
        rd0 = rd_n;
        wr0 = wr_n;
        inj_drdy = 1'b1;
        tick(1);
        inj_drdy = 1'b0;
        tick(2);
        chk("t6_idle_drdy", 32'({bus.busy_o, bus.den_o}), 0);
        start(1);
        bus.count_i = 5'd3;
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
        wait_den("t6_rd");
        bus.start_i = 1'b1;
        tick(1);
        bus.start_i = 1'b0;
        bus.locked_i = 1'b1;
        wait_idle("t6_idle");
        chk("t6_done", 32'(bus.done_o), 1);
        chk("t6_rd_n", rd_n - rd0, 1);
        chk("t6_wr_n", wr_n - wr0, 1);
        bus.locked_i = 1'b0;

        chk("protocol_viol", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
